// File: rtl/tach_conditioner.sv
// Tach front end: 2-flop sync + persistence filter on the raw blips line, rising-edge strobe,
// edge-to-edge period measurement and stall detection. Blips lag a clean raw edge by 2+FILTER_CYCLES clocks.
module tach_conditioner #(
    parameter int FILTER_CYCLES = 500,
    parameter int STALL_CYCLES  = 25000000,
    parameter int PERIOD_W      = 32
) (
    input  logic                clk50M,
    input  logic                reset,
    input  logic                tach_raw,
    output logic                blips,
    output logic                blip_pulse,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                stalled
);

    localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [FW-1:0]       FLAST   = FW'(FILTER_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] STALL_N = PERIOD_W'(STALL_CYCLES);

    typedef enum logic [1:0] {IDLE, ARMED, RUNNING} state_t;

    logic [1:0]          sync_q;
    logic                s;
    logic [FW-1:0]       fcnt_q, fcnt_d;
    logic                blips_q, blips_d;
    logic                blip_pulse_q;
    logic [PERIOD_W-1:0] pcnt_q, pcnt_d, pcnt_inc;
    logic                accept, rise;
    state_t              state_q;
    logic [PERIOD_W-1:0] period_q;
    logic                period_valid_q;
    logic                stalled_q;

    assign s        = sync_q[1];
    assign accept   = (s != blips_q) && (fcnt_q == FLAST);
    assign rise     = accept && s;
    assign pcnt_inc = pcnt_q + 1'b1;

    always_comb begin
        fcnt_d  = fcnt_q;
        blips_d = blips_q;
        if (s == blips_q) begin
            fcnt_d = '0;
        end else if (accept) begin
            fcnt_d  = '0;
            blips_d = s;
        end else begin
            fcnt_d = fcnt_q + 1'b1;
        end

        // Period counter saturates so a long idle never aliases to a short period.
        if (rise)
            pcnt_d = '0;
        else if (&pcnt_q)
            pcnt_d = pcnt_q;
        else
            pcnt_d = pcnt_inc;
    end

    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            sync_q       <= '0;
            fcnt_q       <= '0;
            blips_q      <= 1'b0;
            blip_pulse_q <= 1'b0;
            pcnt_q       <= '0;
        end else begin
            sync_q       <= {sync_q[0], tach_raw};
            fcnt_q       <= fcnt_d;
            blips_q      <= blips_d;
            blip_pulse_q <= rise;
            pcnt_q       <= pcnt_d;
        end
    end

    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            stalled_q      <= 1'b1;
        end else begin
            period_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q   <= ARMED;
                        stalled_q <= 1'b0;
                    end
                end
                ARMED, RUNNING: begin
                    // An edge landing on the stall threshold is still a valid period.
                    if (rise) begin
                        state_q        <= RUNNING;
                        period_q       <= pcnt_inc;
                        period_valid_q <= 1'b1;
                    end else if (pcnt_inc == STALL_N) begin
                        state_q   <= IDLE;
                        stalled_q <= 1'b1;
                        period_q  <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign blips        = blips_q;
    assign blip_pulse   = blip_pulse_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign stalled      = stalled_q;

endmodule

// File: tb/tb_tach_conditioner.sv
// Directed bench for tach_conditioner: filter latency, glitch/bounce rejection, period, stall and reset.
module tb_tach_conditioner;

    localparam int FILT  = 500;
    localparam int STALL = 10000;

    logic        clk50M = 1'b0;
    logic        reset;
    logic        tach_raw;
    logic        blips, blip_pulse, period_valid, stalled;
    logic [31:0] period;

    tach_conditioner #(.FILTER_CYCLES(FILT), .STALL_CYCLES(STALL), .PERIOD_W(32)) dut (
        .clk50M      (clk50M),
        .reset       (reset),
        .tach_raw    (tach_raw),
        .blips       (blips),
        .blip_pulse  (blip_pulse),
        .period      (period),
        .period_valid(period_valid),
        .stalled     (stalled)
    );

    always #10 clk50M = ~clk50M;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t_last = 0;
    int pulses = 0, pv_cnt = 0, blips_hi = 0, stall_evts = 0;
    int last_pulse = 0, stall_cyc = 0;
    int bp_run = 0, bp_max = 0, pv_run = 0, pv_max = 0;
    logic prev_st = 1'b1;
    int pulse_q[$];

    always @(posedge clk50M) cyc <= cyc + 1;

    always @(negedge clk50M) begin
        if (blip_pulse === 1'b1) begin
            pulses++;
            last_pulse = cyc;
            pulse_q.push_back(cyc);
            bp_run++;
            if (bp_run > bp_max) bp_max = bp_run;
        end else begin
            bp_run = 0;
        end
        if (period_valid === 1'b1) begin
            pv_cnt++;
            pv_run++;
            if (pv_run > pv_max) pv_max = pv_run;
        end else begin
            pv_run = 0;
        end
        if (blips === 1'b1) blips_hi++;
        if (stalled === 1'b1 && prev_st === 1'b0) begin
            stall_cyc = cyc;
            stall_evts++;
        end
        prev_st = stalled;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Drive v on a falling edge and keep it for exactly n clocks.
    task automatic hold(input logic v, input int n);
        @(negedge clk50M);
        tach_raw = v;
        t_last = cyc;
        repeat (n - 1) @(negedge clk50M);
    endtask

    int p0, v0, v1, s1, b0, t_first, nwait;

    initial begin
        reset    = 1'b1;
        tach_raw = 1'b0;
        repeat (3) @(negedge clk50M);
        check_eq("rst_blips", blips, 0);
        check_eq("rst_pulse", blip_pulse, 0);
        check_eq("rst_period", period, 0);
        check_eq("rst_pvalid", period_valid, 0);
        check_eq("rst_stalled", stalled, 1);
        reset = 1'b0;
        repeat (5) @(negedge clk50M);

        // Square wave, 2000-clock period
        p0 = pulses; v0 = pv_cnt;
        hold(1'b1, 1000); t_first = t_last; hold(1'b0, 1000);
        for (int i = 0; i < 3; i++) begin
            hold(1'b1, 1000);
            hold(1'b0, 1000);
        end
        check_eq("sq_pulses", pulses - p0, 4);
        check_eq("sq_latency", pulse_q[p0] - t_first, FILT + 2);
        check_eq("sq_interval", pulse_q[p0+3] - pulse_q[p0+2], 2000);
        check_eq("sq_pvalids", pv_cnt - v0, 3);
        check_eq("sq_period", period, 2000);
        check_eq("sq_stalled", stalled, 0);

        // Input stops: stall exactly STALL clocks after the last strobe
        nwait = last_pulse + STALL + 2 - cyc;
        if (nwait < 1) nwait = 1;
        repeat (nwait) @(negedge clk50M);
        check_eq("stall_time", stall_cyc - last_pulse, STALL);
        check_eq("stall_flag", stalled, 1);
        check_eq("stall_period", period, 0);
        check_eq("stall_no_pv", pv_cnt - v0, 3);

        v1 = pv_cnt; s1 = stall_evts;
        hold(1'b1, 1000);
        check_eq("rearm_stalled", stalled, 0);
        check_eq("rearm_no_pv", pv_cnt, v1);
        hold(1'b0, 1000);
        hold(1'b1, 1000);
        check_eq("rearm_pv", pv_cnt, v1 + 1);
        check_eq("rearm_period", period, 2000);

        // Edge exactly on the stall threshold: edge wins
        hold(1'b0, STALL - 1000);
        hold(1'b1, 1000);
        check_eq("thr_pv", pv_cnt, v1 + 2);
        check_eq("thr_period", period, STALL);
        check_eq("thr_stalled", stalled, 0);
        check_eq("thr_no_stall_evt", stall_evts, s1);
        hold(1'b0, 1000);

        // Glitch one clock shy of the filter, then exactly the filter length
        p0 = pulses; b0 = blips_hi;
        hold(1'b1, FILT - 1); hold(1'b0, 2000);
        check_eq("glitch499_pulses", pulses, p0);
        check_eq("glitch499_blips", blips_hi, b0);
        hold(1'b1, FILT); hold(1'b0, 2000);
        check_eq("pulse500_pulses", pulses, p0 + 1);
        check_eq("pulse500_blips_hi", blips_hi - b0, FILT);

        // Bounce for 300 clocks then settle high
        p0 = pulses;
        for (int k = 0; k < 30; k++) hold((k % 2) == 0, 10);
        hold(1'b1, 1000);
        check_eq("bounce_pulses", pulses, p0 + 1);
        check_eq("bounce_latency", last_pulse - t_last, FILT + 2);
        hold(1'b0, 1000);

        // Asynchronous reset mid-run
        hold(1'b1, 1000); hold(1'b0, 1000); hold(1'b1, 700);
        check_eq("pre_rst_blips", blips, 1);
        check_eq("pre_rst_period", period, 2000);
        @(posedge clk50M);
        #3 reset = 1'b1;
        #1;
        check_eq("async_blips", blips, 0);
        check_eq("async_stalled", stalled, 1);
        check_eq("async_period", period, 0);
        tach_raw = 1'b0;
        repeat (3) @(negedge clk50M);
        reset = 1'b0;
        v1 = pv_cnt; p0 = pulses;
        repeat (5) @(negedge clk50M);
        hold(1'b1, 1000); hold(1'b0, 1000);
        check_eq("post_rst_pulse", pulses, p0 + 1);
        check_eq("post_rst_no_pv", pv_cnt, v1);
        hold(1'b1, 1000); hold(1'b0, 1000);
        check_eq("post_rst_pv", pv_cnt, v1 + 1);
        check_eq("post_rst_period", period, 2000);

        check_eq("pulse_width", bp_max, 1);
        check_eq("pvalid_width", pv_max, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
